// File: rtl/mac_sched_if.sv
// Handshake/bus bundle between the MAC job sequencer and its surroundings
// (host, MAC array, writeback stage and result-RAM arbiter).
interface mac_sched_if;
  logic       start;
  logic       abort;
  logic       busy;
  logic       done;
  logic       mac_clr;
  logic       mac_en;
  logic [7:0] in_addr;
  logic [3:0] col_idx;
  logic       web;
  logic       ram_sel;
  logic       host_req;
  logic       host_gnt;

  // Sequencer side: drives the MAC/writeback controls and the RAM grant.
  modport master (
    input  start, abort, host_req,
    output busy, done, mac_clr, mac_en, in_addr, col_idx, web, ram_sel, host_gnt
  );

  // Environment side: issues jobs and host requests, observes the controls.
  modport slave (
    output start, abort, host_req,
    input  busy, done, mac_clr, mac_en, in_addr, col_idx, web, ram_sel, host_gnt
  );
endinterface

// File: rtl/mac_sched.sv
// Job sequencer for the 4-lane MAC array and its writeback stage.
// Each job runs N_COLS columns of CLR -> ACC x ACC_LEN -> DRAIN -> WB x 4,
// then pulses done. The result RAM is shared between the writeback stage,
// which always wins, and a registered host read grant.
module mac_sched #(
  parameter int ACC_LEN = 8,   // accumulate cycles per column (1..255)
  parameter int N_COLS  = 4    // columns per job (1..16)
) (
  input  logic        clk,
  input  logic        rst,     // synchronous, active-low
  mac_sched_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_ACC,
    S_DRAIN,
    S_WB,
    S_DONE
  } state_t;

  localparam logic [7:0] ACC_LAST = 8'(ACC_LEN - 1);
  localparam logic [3:0] COL_LAST = 4'(N_COLS - 1);
  localparam logic [7:0] WB_LAST  = 8'd3;

  state_t     state, next_state;
  logic [7:0] cnt, cnt_nxt;        // ACC step k, or WB beat 0..3
  logic [3:0] col, col_nxt;
  logic [7:0] addr, addr_nxt;
  logic       abort_pend, pend_nxt; // abort seen during a burst, acted on after it
  logic       gnt;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      col        <= '0;
      addr       <= '0;
      abort_pend <= 1'b0;
      gnt        <= 1'b0;
    end else begin
      state      <= next_state;
      cnt        <= cnt_nxt;
      col        <= col_nxt;
      addr       <= addr_nxt;
      abort_pend <= pend_nxt;
      // Grant looks at the state being entered, so it drops one cycle
      // before ram_sel rises and returns the cycle after WB ends.
      gnt        <= bus.host_req && (next_state != S_DRAIN) && (next_state != S_WB);
    end
  end

  // Next-state, counter updates and Moore output decode.
  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case
    // leaves a value unassigned and no latch is inferred.
    next_state = state;
    cnt_nxt    = cnt;
    col_nxt    = col;
    addr_nxt   = addr;
    pend_nxt   = abort_pend;

    unique case (state)
      S_IDLE: begin
        if (bus.start && !bus.abort) next_state = S_CLR;
      end
      S_CLR: begin
        if (bus.abort) begin
          next_state = S_IDLE;
        end else begin
          next_state = S_ACC;
          cnt_nxt    = '0;
          addr_nxt   = 8'(col * ACC_LEN);
        end
      end
      S_ACC: begin
        if (bus.abort) begin
          next_state = S_IDLE;
        end else if (cnt == ACC_LAST) begin
          next_state = S_DRAIN;
        end else begin
          cnt_nxt  = cnt + 8'd1;
          addr_nxt = addr + 8'd1;
        end
      end
      S_DRAIN: begin
        if (bus.abort) begin
          next_state = S_IDLE;
        end else begin
          next_state = S_WB;
          cnt_nxt    = '0;
        end
      end
      S_WB: begin
        // A burst is never torn: abort only takes effect after beat 3.
        if (bus.abort) pend_nxt = 1'b1;
        if (cnt == WB_LAST) begin
          if (abort_pend || bus.abort) begin
            next_state = S_IDLE;
          end else if (col == COL_LAST) begin
            next_state = S_DONE;
          end else begin
            next_state = S_CLR;
            col_nxt    = col + 4'd1;
          end
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      S_DONE: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase

    // Every return to IDLE restarts the column count and forgets any abort.
    if (next_state == S_IDLE) begin
      col_nxt  = '0;
      pend_nxt = 1'b0;
    end

    bus.busy     = (state != S_IDLE);
    bus.done     = (state == S_DONE);
    bus.mac_clr  = (state == S_CLR);
    bus.mac_en   = (state == S_ACC);
    bus.web      = (state == S_WB) && (cnt == '0);
    bus.ram_sel  = (state == S_WB);
    bus.in_addr  = addr;
    bus.col_idx  = col;
    bus.host_gnt = gnt;
  end

endmodule

// File: tb/tb_mac_sched.sv
// Self-checking bench for mac_sched. A cycle-indexed reference model derives
// every expected output from the column timeline (cycle -> column, phase).
module tb_mac_sched;

  localparam int ALEN  = 8;
  localparam int NCOLS = 4;
  localparam int CLEN  = ALEN + 6;          // cycles per column
  localparam int FULL  = NCOLS * CLEN + 1;  // cycle index of done

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       clr;
    logic       en;
    logic       web;
    logic       sel;
    logic       gnt;
    logic [3:0] col;
    logic [7:0] addr;
  } obs_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [7:0] model_addr;   // in_addr holds across jobs, so the model must too

  mac_sched_if mif ();
  mac_sched_if sif ();

  mac_sched #(.ACC_LEN(ALEN), .N_COLS(NCOLS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (mif)
  );

  mac_sched #(.ACC_LEN(1), .N_COLS(1)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t obs_main();
    return {mif.busy, mif.done, mif.mac_clr, mif.mac_en, mif.web, mif.ram_sel,
            mif.host_gnt, mif.col_idx, mif.in_addr};
  endfunction

  function automatic obs_t obs_small();
    return {sif.busy, sif.done, sif.mac_clr, sif.mac_en, sif.web, sif.ram_sel,
            sif.host_gnt, sif.col_idx, sif.in_addr};
  endfunction

  // Runs one job on the main DUT. Cycle c=1 is the cycle after the edge that
  // samples start. req_mode: 0 host_req low, 1 held high, 2 random.
  // abort_at > 0 raises abort for that single cycle. extra_start fires random
  // start pulses while busy, then start+abort together once idle.
  task automatic run_job(input int abort_at, input int req_mode, input bit extra_start,
                         output int n_done, output int n_web, output int done_cyc);
    int   e, p, col;
    bit   prev_req, in_drain;
    obs_t exp_o, got;
    e = FULL;
    if (abort_at > 0 && abort_at < FULL) begin
      p = (abort_at - 1) % CLEN;
      if (p <= ALEN + 1) e = abort_at;                 // CLR/ACC/DRAIN: stop now
      else               e = abort_at + (ALEN + 5 - p); // WB: finish the burst
    end
    n_done = 0; n_web = 0; done_cyc = 0;

    @(negedge clk);
    mif.start    = 1'b1;
    mif.abort    = 1'b0;
    mif.host_req = (req_mode == 2) ? 1'($urandom_range(0, 1)) : (req_mode == 1);
    prev_req     = mif.host_req;

    for (int c = 1; c <= FULL + 4; c++) begin
      @(negedge clk);
      exp_o    = '0;
      in_drain = 1'b0;
      if (c <= e) begin
        exp_o.busy = 1'b1;
        if (c == FULL) begin
          exp_o.done = 1'b1;
          exp_o.col  = 4'(NCOLS - 1);
        end else begin
          p         = (c - 1) % CLEN;
          col       = (c - 1) / CLEN;
          exp_o.col = 4'(col);
          exp_o.clr = (p == 0);
          exp_o.en  = (p >= 1 && p <= ALEN);
          if (exp_o.en) model_addr = 8'(col * ALEN + p - 1);
          in_drain  = (p == ALEN + 1);
          exp_o.web = (p == ALEN + 2);
          exp_o.sel = (p >= ALEN + 2);
        end
      end
      exp_o.addr = model_addr;
      exp_o.gnt  = prev_req && !in_drain && !exp_o.sel;

      got = obs_main();
      n_checks++;
      if (got !== exp_o) begin
        n_fail++;
        $display("FAIL outputs cycle=%0d abort_at=%0d: got busy/done/clr/en/web/sel/gnt=%b%b%b%b%b%b%b col=%0d addr=%0d, expected %b%b%b%b%b%b%b col=%0d addr=%0d",
                 c, abort_at, got.busy, got.done, got.clr, got.en, got.web, got.sel, got.gnt,
                 got.col, got.addr, exp_o.busy, exp_o.done, exp_o.clr, exp_o.en, exp_o.web,
                 exp_o.sel, exp_o.gnt, exp_o.col, exp_o.addr);
      end
      n_checks++;
      if ((mif.host_gnt && mif.ram_sel) !== 1'b0) begin
        n_fail++;
        $display("FAIL ownership_overlap cycle=%0d: host_gnt=%b ram_sel=%b, required not both 1",
                 c, mif.host_gnt, mif.ram_sel);
      end
      if (mif.done === 1'b1) begin n_done++; done_cyc = c; end
      if (mif.web === 1'b1) n_web++;

      mif.start    = extra_start && (c < e) ? 1'($urandom_range(0, 1)) : 1'b0;
      mif.abort    = (c == abort_at);
      if (extra_start && c == e + 1) begin
        mif.start = 1'b1;
        mif.abort = 1'b1;
      end
      mif.host_req = (req_mode == 2) ? 1'($urandom_range(0, 1)) : (req_mode == 1);
      prev_req     = mif.host_req;
    end
    mif.start    = 1'b0;
    mif.abort    = 1'b0;
    mif.host_req = 1'b0;
  endtask

  task automatic test_reset();
    obs_t got;
    rst = 1'b0;
    mif.start = 1'b1; mif.abort = 1'b0; mif.host_req = 1'b1;
    sif.start = 1'b1; sif.abort = 1'b0; sif.host_req = 1'b1;
    repeat (2) @(negedge clk);
    got = obs_main();
    n_checks++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL reset_main: got %h, expected 0", got);
    end
    got = obs_small();
    n_checks++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL reset_small: got %h, expected 0", got);
    end
    mif.start = 1'b0; mif.host_req = 1'b0;
    sif.start = 1'b0; sif.host_req = 1'b0;
    rst = 1'b1;
    model_addr = '0;
    @(negedge clk);
  endtask

  task automatic test_full_job();
    int nd, nw, dc;
    run_job(0, 0, 1'b0, nd, nw, dc);
    n_checks++;
    if (dc !== FULL || nd !== 1) begin
      n_fail++;
      $display("FAIL full_job_done: done at cycle %0d (count %0d), expected cycle %0d (count 1)", dc, nd, FULL);
    end
    n_checks++;
    if (nw !== NCOLS) begin
      n_fail++;
      $display("FAIL full_job_web: %0d web pulses, expected %0d", nw, NCOLS);
    end
  endtask

  task automatic test_host_hold();
    int nd, nw, dc;
    run_job(0, 1, 1'b0, nd, nw, dc);
    n_checks++;
    if (nd !== 1) begin
      n_fail++;
      $display("FAIL host_hold_done: %0d done pulses, expected 1", nd);
    end
  endtask

  task automatic test_abort_acc();
    int nd, nw, dc;
    // Column 1 starts at cycle CLEN+1 (CLR); its ACC step k=3 is 4 cycles later.
    run_job(CLEN + 5, 2, 1'b0, nd, nw, dc);
    n_checks++;
    if (nd !== 0 || nw !== 1) begin
      n_fail++;
      $display("FAIL abort_acc: done=%0d web=%0d, expected done=0 web=1", nd, nw);
    end
  endtask

  task automatic test_abort_wb();
    int nd, nw, dc;
    run_job(ALEN + 4, 1, 1'b0, nd, nw, dc);   // second WB cycle of column 0
    n_checks++;
    if (nd !== 0 || nw !== 1) begin
      n_fail++;
      $display("FAIL abort_wb: done=%0d web=%0d, expected done=0 web=1", nd, nw);
    end
  endtask

  task automatic test_back_to_back();
    int nd, nw, dc;
    run_job(0, 2, 1'b1, nd, nw, dc);
    n_checks++;
    if (nd !== 1 || dc !== FULL) begin
      n_fail++;
      $display("FAIL ignored_start: done count %0d at cycle %0d, expected 1 at cycle %0d", nd, dc, FULL);
    end
  endtask

  task automatic test_random_abort();
    int nd, nw, dc, ca;
    for (int i = 0; i < 4; i++) begin
      ca = $urandom_range(1, FULL);
      run_job(ca, 2, 1'b0, nd, nw, dc);
      n_checks++;
      if (nd !== ((ca == FULL) ? 1 : 0)) begin
        n_fail++;
        $display("FAIL random_abort abort_at=%0d: %0d done pulses, expected %0d",
                 ca, nd, (ca == FULL) ? 1 : 0);
      end
    end
  endtask

  task automatic test_reset_mid_wb();
    obs_t got;
    int   nd, nw, dc;
    @(negedge clk);
    mif.start = 1'b1; mif.host_req = 1'b1;
    for (int c = 1; c <= ALEN + 4; c++) begin
      @(negedge clk);
      mif.start = 1'b0;
    end
    rst = 1'b0;                                  // held over one edge, mid-WB
    @(negedge clk);
    got = obs_main();
    n_checks++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_wb: got %h, expected 0", got);
    end
    rst = 1'b1;
    mif.host_req = 1'b0;
    model_addr = '0;
    run_job(0, 2, 1'b0, nd, nw, dc);
    n_checks++;
    if (dc !== FULL || nw !== NCOLS) begin
      n_fail++;
      $display("FAIL job_after_reset: done cycle %0d web %0d, expected %0d and %0d", dc, nw, FULL, NCOLS);
    end
  endtask

  // ACC_LEN=1, N_COLS=1: CLR, ACC, DRAIN, WB x4, DONE at cycle 8.
  task automatic test_small();
    obs_t got, exp_o;
    @(negedge clk);
    sif.start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      sif.start = 1'b0;
      exp_o      = '0;
      exp_o.busy = (c <= 8);
      exp_o.done = (c == 8);
      exp_o.clr  = (c == 1);
      exp_o.en   = (c == 2);
      exp_o.web  = (c == 4);
      exp_o.sel  = (c >= 4 && c <= 7);
      got = obs_small();
      n_checks++;
      if (got !== exp_o) begin
        n_fail++;
        $display("FAIL small_job cycle=%0d: got %h, expected %h", c, got, exp_o);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    mif.start = 1'b0; mif.abort = 1'b0; mif.host_req = 1'b0;
    sif.start = 1'b0; sif.abort = 1'b0; sif.host_req = 1'b0;
    model_addr = '0;
    test_reset();
    test_full_job();
    test_host_hold();
    test_abort_acc();
    test_abort_wb();
    test_back_to_back();
    test_random_abort();
    test_reset_mid_wb();
    test_small();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
